// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Two-source writeback arbiter. Picks at most one of the
//               integer pipe (ip, index 0) or load/store pipe (lsp, index 1)
//               per cycle, registers the accepted writeback and emits
//               one-cycle regfile-write, scoreboard-clear and retire strobes.
//               Contention is resolved round-robin on a 1-bit last-grant.
// Ports       : clk, rst                        - clock, sync active-high reset
//               ip_wb_*  / lsp_wb_*             - per-source request (dst,
//                                                 result, pc, wb_en, valid)
//                                                 and combinational ready
//               rf_wen, rf_wdst, rf_wdata       - regfile write port
//               wb_ix_clear_valid/_dst          - scoreboard clear
//               wb_retire_valid/_pc/_src        - retire report
//               wb_instret                      - retired count (optional)
// Config      : WB_INSTRET_EN - when defined, adds the 64-bit wb_instret
//               counter port; when undefined the port and counter are absent.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [4:0]  ip_wb_dst,
  input  logic [63:0] ip_wb_result,
  input  logic [63:0] ip_wb_pc,
  input  logic        ip_wb_wb_en,
  input  logic        ip_wb_valid,
  output logic        ip_wb_ready,

  input  logic [4:0]  lsp_wb_dst,
  input  logic [63:0] lsp_wb_result,
  input  logic [63:0] lsp_wb_pc,
  input  logic        lsp_wb_wb_en,
  input  logic        lsp_wb_valid,
  output logic        lsp_wb_ready,

  output logic        rf_wen,
  output logic [4:0]  rf_wdst,
  output logic [63:0] rf_wdata,

  output logic        wb_ix_clear_valid,
  output logic [4:0]  wb_ix_clear_dst,

  output logic        wb_retire_valid,
  output logic [63:0] wb_retire_pc,
  output logic        wb_retire_src
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] wb_instret
`endif
);

  // Grant index width; the source set is fixed at two so this is one bit.
  localparam int GRANT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [GRANT_W-1:0] GRANT_IP  = GRANT_W'(0);
  localparam logic [GRANT_W-1:0] GRANT_LSP = GRANT_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [GRANT_W-1:0] last_grant_q, last_grant_d;
  logic               wen_q,        wen_d;
  logic               retire_q,     retire_d;
  logic [4:0]         dst_q,        dst_d;
  logic [63:0]        data_q,       data_d;
  logic [63:0]        pc_q,         pc_d;
  logic               src_q,        src_d;

  // --------------------------------------------------------------------------
  // Arbitration. The output stage always drains, so a lone valid source is
  // accepted immediately. With nothing pending, ip is parked ready.
  // --------------------------------------------------------------------------
  always_comb begin
    ip_wb_ready  = 1'b0;
    lsp_wb_ready = 1'b0;
    if (!rst) begin
      if (ip_wb_valid && lsp_wb_valid) begin
        // Contention: grant the source that did not win last time.
        ip_wb_ready  = (last_grant_q == GRANT_LSP);
        lsp_wb_ready = (last_grant_q == GRANT_IP);
      end else if (lsp_wb_valid) begin
        lsp_wb_ready = 1'b1;
      end else begin
        ip_wb_ready  = 1'b1;
      end
    end
  end

  logic        w_ip_xfer;
  logic        w_lsp_xfer;
  logic        w_xfer;
  logic [4:0]  w_dst;
  logic [63:0] w_result;
  logic [63:0] w_pc;
  logic        w_wb_en;

  assign w_ip_xfer  = ip_wb_valid  && ip_wb_ready;
  assign w_lsp_xfer = lsp_wb_valid && lsp_wb_ready;
  assign w_xfer     = w_ip_xfer || w_lsp_xfer;

  // At most one of the two transfers can be active, so select on lsp.
  assign w_dst    = w_lsp_xfer ? lsp_wb_dst    : ip_wb_dst;
  assign w_result = w_lsp_xfer ? lsp_wb_result : ip_wb_result;
  assign w_pc     = w_lsp_xfer ? lsp_wb_pc     : ip_wb_pc;
  assign w_wb_en  = w_lsp_xfer ? lsp_wb_wb_en  : ip_wb_wb_en;

  // --------------------------------------------------------------------------
  // Next state. Strobes are single-cycle pulses; payload registers only move
  // on a transfer and otherwise hold their last value.
  // --------------------------------------------------------------------------
  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    retire_d     = 1'b0;
    dst_d        = dst_q;
    data_d       = data_q;
    pc_d         = pc_q;
    src_d        = src_q;
    if (w_xfer) begin
      last_grant_d = w_lsp_xfer ? GRANT_LSP : GRANT_IP;
      // x0 is hardwired zero: never write it or clear its scoreboard bit.
      wen_d        = w_wb_en && (w_dst != 5'd0);
      retire_d     = 1'b1;
      dst_d        = w_dst;
      data_d       = w_result;
      pc_d         = w_pc;
      src_d        = w_lsp_xfer;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // lsp as last winner makes the first contention after reset go to ip.
      last_grant_q <= GRANT_LSP;
      wen_q        <= 1'b0;
      retire_q     <= 1'b0;
      dst_q        <= 5'd0;
      data_q       <= 64'd0;
      pc_q         <= 64'd0;
      src_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      retire_q     <= retire_d;
      dst_q        <= dst_d;
      data_q       <= data_d;
      pc_q         <= pc_d;
      src_q        <= src_d;
    end
  end

  assign rf_wen            = wen_q;
  assign rf_wdst           = dst_q;
  assign rf_wdata          = data_q;
  // Scoreboard clear fires on exactly the same condition as the regfile write.
  assign wb_ix_clear_valid = wen_q;
  assign wb_ix_clear_dst   = dst_q;
  assign wb_retire_valid   = retire_q;
  assign wb_retire_pc      = pc_q;
  assign wb_retire_src     = src_q;

`ifdef WB_INSTRET_EN
  // Counts on the transfer edge so the new value lines up with the retire
  // pulse; wraps naturally at 2^64.
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= 64'd0;
    end else if (w_xfer) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign wb_instret = instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter. A table of per-cycle
//               input/expected-output records covers arbitration and the
//               registered strobes; short hand-written sequences cover
//               reset, mid-stream reset and the optional retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic [4:0]  ip_wb_dst;
  logic [63:0] ip_wb_result;
  logic [63:0] ip_wb_pc;
  logic        ip_wb_wb_en;
  logic        ip_wb_valid;
  logic        ip_wb_ready;
  logic [4:0]  lsp_wb_dst;
  logic [63:0] lsp_wb_result;
  logic [63:0] lsp_wb_pc;
  logic        lsp_wb_wb_en;
  logic        lsp_wb_valid;
  logic        lsp_wb_ready;
  logic        rf_wen;
  logic [4:0]  rf_wdst;
  logic [63:0] rf_wdata;
  logic        wb_ix_clear_valid;
  logic [4:0]  wb_ix_clear_dst;
  logic        wb_retire_valid;
  logic [63:0] wb_retire_pc;
  logic        wb_retire_src;
`ifdef WB_INSTRET_EN
  logic [63:0] wb_instret;
`endif

  wb_arbiter #(.NUM_SRC(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .ip_wb_dst         (ip_wb_dst),
    .ip_wb_result      (ip_wb_result),
    .ip_wb_pc          (ip_wb_pc),
    .ip_wb_wb_en       (ip_wb_wb_en),
    .ip_wb_valid       (ip_wb_valid),
    .ip_wb_ready       (ip_wb_ready),
    .lsp_wb_dst        (lsp_wb_dst),
    .lsp_wb_result     (lsp_wb_result),
    .lsp_wb_pc         (lsp_wb_pc),
    .lsp_wb_wb_en      (lsp_wb_wb_en),
    .lsp_wb_valid      (lsp_wb_valid),
    .lsp_wb_ready      (lsp_wb_ready),
    .rf_wen            (rf_wen),
    .rf_wdst           (rf_wdst),
    .rf_wdata          (rf_wdata),
    .wb_ix_clear_valid (wb_ix_clear_valid),
    .wb_ix_clear_dst   (wb_ix_clear_dst),
    .wb_retire_valid   (wb_retire_valid),
    .wb_retire_pc      (wb_retire_pc),
    .wb_retire_src     (wb_retire_src)
`ifdef WB_INSTRET_EN
    ,
    .wb_instret        (wb_instret)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;  logic [4:0] id; logic [63:0] ir; logic [63:0] ipc; logic ie;
    logic        lv;  logic [4:0] ld; logic [63:0] lr; logic [63:0] lpc; logic le;
    logic        e_ir; logic e_lr;
    logic        e_wen; logic [4:0] e_dst; logic [63:0] e_data;
    logic        e_ret; logic [63:0] e_pc; logic e_src;
  } vec_t;

  function automatic vec_t mk(
    input logic iv, input logic [4:0] id, input logic [63:0] ir, input logic [63:0] ipc, input logic ie,
    input logic lv, input logic [4:0] ld, input logic [63:0] lr, input logic [63:0] lpc, input logic le,
    input logic e_ir, input logic e_lr,
    input logic e_wen, input logic [4:0] e_dst, input logic [63:0] e_data,
    input logic e_ret, input logic [63:0] e_pc, input logic e_src);
    vec_t v;
    v.iv = iv; v.id = id; v.ir = ir; v.ipc = ipc; v.ie = ie;
    v.lv = lv; v.ld = ld; v.lr = lr; v.lpc = lpc; v.le = le;
    v.e_ir = e_ir; v.e_lr = e_lr;
    v.e_wen = e_wen; v.e_dst = e_dst; v.e_data = e_data;
    v.e_ret = e_ret; v.e_pc = e_pc; v.e_src = e_src;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ip_wb_valid  = v.iv; ip_wb_dst  = v.id; ip_wb_result  = v.ir; ip_wb_pc  = v.ipc; ip_wb_wb_en  = v.ie;
    lsp_wb_valid = v.lv; lsp_wb_dst = v.ld; lsp_wb_result = v.lr; lsp_wb_pc = v.lpc; lsp_wb_wb_en = v.le;
  endtask

  task automatic chk_strobes_zero(input string tag);
    chk({tag, " rf_wen"},      64'(rf_wen),            64'd0);
    chk({tag, " clear_valid"}, 64'(wb_ix_clear_valid), 64'd0);
    chk({tag, " retire_valid"},64'(wb_retire_valid),   64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    // Expected outputs describe the cycle after the inputs are applied.
    //            ---------------- ip ----------------   --------------- lsp ---------------  rdy     wen dst    data              ret pc              src
    vecs[0]  = mk(1, 5'd1, 64'h11, 64'h100, 1,           1, 5'd2, 64'h22, 64'h200, 1,         1, 0,   1, 5'd1,  64'h11,           1, 64'h100,         0);
    vecs[1]  = mk(1, 5'd1, 64'h11, 64'h100, 1,           1, 5'd2, 64'h22, 64'h200, 1,         0, 1,   1, 5'd2,  64'h22,           1, 64'h200,         1);
    vecs[2]  = mk(1, 5'd1, 64'h11, 64'h100, 1,           1, 5'd2, 64'h22, 64'h200, 1,         1, 0,   1, 5'd1,  64'h11,           1, 64'h100,         0);
    vecs[3]  = mk(1, 5'd1, 64'h11, 64'h100, 1,           1, 5'd2, 64'h22, 64'h200, 1,         0, 1,   1, 5'd2,  64'h22,           1, 64'h200,         1);
    vecs[4]  = mk(0, 5'd9, 64'h99, 64'h900, 1,           0, 5'd9, 64'h99, 64'h900, 1,         1, 0,   0, 5'd2,  64'h22,           0, 64'h200,         1);
    vecs[5]  = mk(1, 5'd5, 64'hDEAD_BEEF, 64'h8000_0000, 1, 0, 5'd3, 64'h98, 64'h980, 1,      1, 0,   1, 5'd5,  64'hDEAD_BEEF,    1, 64'h8000_0000,   0);
    vecs[6]  = mk(0, 5'd6, 64'h97, 64'h970, 1,           1, 5'd0, 64'h33, 64'h300, 1,         0, 1,   0, 5'd0,  64'h33,           1, 64'h300,         1);
    vecs[7]  = mk(1, 5'd7, 64'h44, 64'h400, 0,           0, 5'd8, 64'h96, 64'h960, 1,         1, 0,   0, 5'd7,  64'h44,           1, 64'h400,         0);
    vecs[8]  = mk(0, 5'd1, 64'h95, 64'h950, 1,           1, 5'd9, 64'h55, 64'h500, 1,         0, 1,   1, 5'd9,  64'h55,           1, 64'h500,         1);
    vecs[9]  = mk(0, 5'd1, 64'h94, 64'h940, 1,           1, 5'd10, 64'h66, 64'h600, 1,        0, 1,   1, 5'd10, 64'h66,           1, 64'h600,         1);
    vecs[10] = mk(1, 5'd3, 64'h77, 64'h700, 1,           1, 5'd4, 64'h88, 64'h800, 1,         1, 0,   1, 5'd3,  64'h77,           1, 64'h700,         0);
    vecs[11] = mk(0, 5'd3, 64'h77, 64'h700, 1,           0, 5'd4, 64'h88, 64'h800, 1,         1, 0,   0, 5'd3,  64'h77,           0, 64'h700,         0);

    // Reset held for two cycles with both sources requesting.
    rst = 1'b1;
    drive(vecs[0]);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("rst ip_ready",  64'(ip_wb_ready),  64'd0);
      chk("rst lsp_ready", 64'(lsp_wb_ready), 64'd0);
      chk_strobes_zero("rst");
      chk("rst rf_wdst",   64'(rf_wdst),       64'd0);
      chk("rst rf_wdata",  rf_wdata,           64'd0);
      chk("rst retire_pc", wb_retire_pc,       64'd0);
      chk("rst retire_src",64'(wb_retire_src), 64'd0);
`ifdef WB_INSTRET_EN
      chk("rst instret",   wb_instret,         64'd0);
`endif
    end

    // Table-driven section; reset deasserts with the first vector.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d ip_ready", i),  64'(ip_wb_ready),  64'(vecs[i].e_ir));
      chk($sformatf("v%0d lsp_ready", i), 64'(lsp_wb_ready), 64'(vecs[i].e_lr));
      @(posedge clk); #1;
      chk($sformatf("v%0d rf_wen", i),      64'(rf_wen),            64'(vecs[i].e_wen));
      chk($sformatf("v%0d rf_wdst", i),     64'(rf_wdst),           64'(vecs[i].e_dst));
      chk($sformatf("v%0d rf_wdata", i),    rf_wdata,               vecs[i].e_data);
      chk($sformatf("v%0d clr_valid", i),   64'(wb_ix_clear_valid), 64'(vecs[i].e_wen));
      chk($sformatf("v%0d clr_dst", i),     64'(wb_ix_clear_dst),   64'(vecs[i].e_dst));
      chk($sformatf("v%0d retire_valid", i),64'(wb_retire_valid),   64'(vecs[i].e_ret));
      chk($sformatf("v%0d retire_pc", i),   wb_retire_pc,           vecs[i].e_pc);
      chk($sformatf("v%0d retire_src", i),  64'(wb_retire_src),     64'(vecs[i].e_src));
    end

    // Mid-stream reset: last winner is ip, so contention goes lsp then ip.
    @(negedge clk);
    drive(vecs[0]);
    #1;
    chk("mid c0 lsp_ready", 64'(lsp_wb_ready), 64'd1);
    chk("mid c0 ip_ready",  64'(ip_wb_ready),  64'd0);
    @(negedge clk); #1;
    chk("mid c1 ip_ready",  64'(ip_wb_ready),  64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst ip_ready",  64'(ip_wb_ready),  64'd0);
    chk("mid rst lsp_ready", 64'(lsp_wb_ready), 64'd0);
    @(posedge clk); #1;
    chk_strobes_zero("mid rst");
    chk("mid rst rf_wdata", rf_wdata, 64'd0);
`ifdef WB_INSTRET_EN
    chk("mid rst instret", wb_instret, 64'd0);
`endif
    // Without the reset the next winner would be lsp; reset forces ip.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post rst ip_ready",  64'(ip_wb_ready),  64'd1);
    chk("post rst lsp_ready", 64'(lsp_wb_ready), 64'd0);
    @(posedge clk); #1;
    chk("post rst retire_valid", 64'(wb_retire_valid), 64'd1);
    chk("post rst retire_src",   64'(wb_retire_src),   64'd0);
    chk("post rst rf_wdst",      64'(rf_wdst),         64'd1);

`ifdef WB_INSTRET_EN
    // One transfer so far since reset; nine more back-to-back lone-ip ones.
    @(negedge clk);
    lsp_wb_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("instret after 10", wb_instret, 64'd10);
    @(negedge clk);
    ip_wb_valid = 1'b0;
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    ip_wb_valid = 1'b1;
    @(posedge clk); #1;
    chk("instret wrap", wb_instret, 64'd0);
`endif

    @(negedge clk);
    ip_wb_valid  = 1'b0;
    lsp_wb_valid = 1'b0;
    @(posedge clk); #1;
    chk_strobes_zero("idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning number of writeback sources (fixed at 2: index 0 = integer pipe "ip", index 1 = load/store pipe "lsp").
REQ-002 SHALL have ports: clk  in  1  clock, all logic posedge; rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: ip_wb_dst  in  5  dest reg; ip_wb_result  in  64  data; ip_wb_pc  in  64  PC; ip_wb_wb_en  in  1  write enable; ip_wb_valid  in  1  request; ip_wb_ready  out  1  accept.
REQ-004 SHALL have ports: lsp_wb_dst  in  5; lsp_wb_result  in  64; lsp_wb_pc  in  64; lsp_wb_wb_en  in  1; lsp_wb_valid  in  1; lsp_wb_ready  out  1 (same meanings as REQ-003).
REQ-005 SHALL have ports: rf_wen  out  1  regfile write strobe; rf_wdst  out  5  regfile index; rf_wdata  out  64  regfile data.
REQ-006 SHALL have ports: wb_ix_clear_valid  out  1  scoreboard clear strobe; wb_ix_clear_dst  out  5  reg to clear.
REQ-007 SHALL have ports: wb_retire_valid  out  1  instruction retired; wb_retire_pc  out  64  retired PC; wb_retire_src  out  1  0=ip, 1=lsp.
REQ-008 SHALL have port wb_instret  out  64  retired-instruction count (present only per REQ-024).

Function
REQ-009 SHALL accept at most one source per cycle; a transfer occurs on a source when valid && ready in the same cycle.
REQ-010 SHALL drive ready combinationally: only one valid -> that source ready=1, other 0; both valid -> round-robin grant per REQ-011; none valid -> ip_wb_ready=1, lsp_wb_ready=0.
REQ-011 SHALL keep 1-bit last_grant; on contention grant the source not equal to last_grant; last_grant updates to the granted index on every transfer.
REQ-012 SHALL never assert ready from valid-independent backpressure; output stage always drains (regfile never stalls), so a lone valid source is accepted the same cycle.
REQ-013 SHALL register the accepted transfer; all outputs of REQ-005..007 valid exactly 1 cycle after the transfer cycle, held for 1 cycle only (pulse).
REQ-014 SHALL assert rf_wen only if accepted wb_en=1 and dst!=0; rf_wdst/rf_wdata carry accepted dst/result.
REQ-015 SHALL assert wb_ix_clear_valid under the same condition as rf_wen, with wb_ix_clear_dst=dst.
REQ-016 SHALL assert wb_retire_valid for every transfer regardless of wb_en or dst, with wb_retire_pc=pc and wb_retire_src=granted index.
REQ-017 SHALL hold rf_wdst, rf_wdata, wb_retire_pc, wb_retire_src, wb_ix_clear_dst at last value in cycles with no transfer.
REQ-018 Back-to-back: transfers on consecutive cycles SHALL produce strobes on consecutive cycles with no bubble.
REQ-019 Contention for N cycles SHALL alternate grants ip, lsp, ip, ... starting from the source opposite last_grant.

Reset
REQ-020 On rst SHALL clear rf_wen, wb_ix_clear_valid, wb_retire_valid to 0 in the next cycle.
REQ-021 On rst SHALL set last_grant=1 (lsp) so first contention grants ip.
REQ-022 On rst SHALL reset rf_wdst, wb_ix_clear_dst to 0, rf_wdata, wb_retire_pc to 0, wb_retire_src to 0.
REQ-023 Ready outputs SHALL be 0 while rst=1; a transfer presented during rst is dropped and produces no strobe.

Configuration
REQ-024 Macro WB_INSTRET_EN: defined -> wb_instret is a 64-bit counter, reset 0, +1 the cycle after each transfer (aligned with wb_retire_valid), wraps 2^64-1 -> 0; undefined -> port absent, no counter logic, all other behaviour identical.

Verification
REQ-025 Reset: hold rst 2 cycles, both valid=1 -> both ready=0, no strobes; release -> first cycle grants ip (ip_wb_ready=1, lsp_wb_ready=0).
REQ-026 Lone ip: ip dst=5, result=0xDEAD_BEEF, pc=0x8000_0000, wb_en=1 -> next cycle rf_wen=1, rf_wdst=5, rf_wdata=0xDEAD_BEEF, clear_dst=5, retire_pc=0x8000_0000, src=0.
REQ-027 x0/no-wb: lsp dst=0 wb_en=1, then ip dst=7 wb_en=0 -> two retire pulses (src 1 then 0), rf_wen and clear_valid stay 0.
REQ-028 Contention: both valid 4 cycles after reset -> grant order ip, lsp, ip, lsp; retire_src 0,1,0,1 on consecutive cycles.
REQ-029 Counter (WB_INSTRET_EN defined): 10 back-to-back transfers -> wb_instret=10 one cycle after last; preload near 2^64-1 via force -> wraps to 0.
REQ-030 Mid-stream reset: rst asserted during contention -> strobes 0 next cycle, wb_instret=0, after release ip granted first.
